cpu7_timer: RTL and testbench

CPU7_TIMER -- requirements
Module: cpu7_timer

---
 rtl/cpu7_timer.sv | 54 +++++
 tb/tb_cpu7_timer.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/cpu7_timer.sv
// cpu7_timer: LoongArch-style constant timer CSRs (TID/TCFG/TVAL/TICLR) and 64-bit stable counter
// ports: clk, resetn (async, active-low); csr_raddr -> csr_rdata (combinational);
//        csr_waddr/csr_wdata/csr_wen write port; timer_int = TI level; stable_cnt free-running
module cpu7_timer #(
   parameter int GRLEN   = 32,
   parameter int CSR_BIT = 14
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic [CSR_BIT-1:0] csr_raddr,
   output logic [GRLEN-1:0]   csr_rdata,
   input  logic [CSR_BIT-1:0] csr_waddr,
   input  logic [GRLEN-1:0]   csr_wdata,
   input  logic               csr_wen,
   output logic               timer_int,
   output logic [63:0]        stable_cnt
);
   localparam logic [CSR_BIT-1:0] A_TID   = CSR_BIT'(32'h40);
   localparam logic [CSR_BIT-1:0] A_TCFG  = CSR_BIT'(32'h41);
   localparam logic [CSR_BIT-1:0] A_TVAL  = CSR_BIT'(32'h42);
   localparam logic [CSR_BIT-1:0] A_TICLR = CSR_BIT'(32'h44);
   logic [GRLEN-1:0] tid, tcfg, tval, tval_nxt;
   logic             ti, w_tid, w_tcfg, w_clr, expire;
   assign w_tid     = csr_wen && csr_waddr == A_TID;
   assign w_tcfg    = csr_wen && csr_waddr == A_TCFG;
   assign w_clr     = csr_wen && csr_waddr == A_TICLR && csr_wdata[0];
   // expiry is judged on the pre-write config, so a same-cycle TCFG write still lets TI set
   assign expire    = tcfg[0] && tval == GRLEN'(1);
   assign timer_int = ti;
   always_comb begin
      tval_nxt  = w_tcfg        ? {csr_wdata[GRLEN-1:2], 2'b00} :
                  !tcfg[0]      ? tval :
                  tval != '0    ? tval - GRLEN'(1) :
                  tcfg[1]       ? {tcfg[GRLEN-1:2], 2'b00} : tval;
      csr_rdata = csr_raddr == A_TID  ? tid  :
                  csr_raddr == A_TCFG ? tcfg :
                  csr_raddr == A_TVAL ? tval : '0;
   end
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         tid        <= '0;
         tcfg       <= '0;
         tval       <= '0;
         ti         <= 1'b0;
         stable_cnt <= '0;
      end else begin
         if (w_tid) tid <= csr_wdata;
         if (w_tcfg) tcfg <= csr_wdata;
         tval       <= tval_nxt;
         ti         <= expire || (ti && !w_clr);
         stable_cnt <= stable_cnt + 64'd1;
      end
   end
endmodule

// File: tb/tb_cpu7_timer.sv
// tb_cpu7_timer: directed self-checking bench for cpu7_timer
module tb_cpu7_timer;
   logic        clk = 1'b0, resetn = 1'b0, csr_wen = 1'b0, timer_int;
   logic [13:0] csr_raddr = '0, csr_waddr = '0;
   logic [31:0] csr_rdata, csr_wdata = '0;
   logic [63:0] stable_cnt, exp_cnt;
   int          checks = 0, failures = 0;
   logic [31:0] pv [4] = '{32'd2, 32'd1, 32'd0, 32'd4};
   logic        pt [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
   always #5 clk = ~clk;
   cpu7_timer dut (
      .clk(clk), .resetn(resetn), .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
      .csr_waddr(csr_waddr), .csr_wdata(csr_wdata), .csr_wen(csr_wen),
      .timer_int(timer_int), .stable_cnt(stable_cnt)
   );
   always @(posedge clk or negedge resetn) exp_cnt <= !resetn ? 64'd0 : exp_cnt + 64'd1;
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic ck_reg(input string tag, input logic [13:0] a, input logic [31:0] exp);
      csr_raddr = a;
      #1;
      chk(tag, {32'd0, csr_rdata}, {32'd0, exp});
   endtask
   task automatic wr(input logic [13:0] a, input logic [31:0] d);
      csr_waddr = a;
      csr_wdata = d;
      csr_wen   = 1'b1;
      @(negedge clk);
      csr_wen   = 1'b0;
   endtask
   initial begin
      repeat (2) @(negedge clk);
      ck_reg("rst_tval", 14'h42, 32'd0);
      chk("rst_ti", timer_int, 64'd0);
      chk("rst_cnt", stable_cnt, 64'd0);
      resetn = 1'b1;
      @(negedge clk);
      chk("cnt1", stable_cnt, 64'd1);
      @(negedge clk);
      chk("cnt2", stable_cnt, 64'd2);
      ck_reg("tcfg0", 14'h41, 32'd0);
      ck_reg("tval0", 14'h42, 32'd0);
      ck_reg("tid0", 14'h40, 32'd0);
      chk("ti0", timer_int, 64'd0);
      wr(14'h41, 32'h9);
      for (int i = 8; i >= 0; i--) begin
         ck_reg("os_tval", 14'h42, 32'(i));
         chk("os_ti", timer_int, 64'(i == 0));
         @(negedge clk);
      end
      for (int i = 0; i < 20; i++) begin
         ck_reg("os_hold", 14'h42, 32'd0);
         chk("os_ti_hold", timer_int, 64'd1);
         @(negedge clk);
      end
      wr(14'h40, 32'hdeadbeef);
      ck_reg("tid_wr", 14'h40, 32'hdeadbeef);
      csr_raddr = 14'h40;
      csr_waddr = 14'h40;
      csr_wdata = 32'h12345678;
      csr_wen   = 1'b1;
      #1;
      chk("tid_old", {32'd0, csr_rdata}, {32'd0, 32'hdeadbeef});
      @(negedge clk);
      csr_wen = 1'b0;
      ck_reg("tid_new", 14'h40, 32'h12345678);
      wr(14'h42, 32'd123);
      ck_reg("tval_ro", 14'h42, 32'd0);
      wr(14'h43, 32'hffffffff);
      ck_reg("unmapped", 14'h43, 32'd0);
      ck_reg("ticlr_rd", 14'h44, 32'd0);
      ck_reg("tcfg_rd", 14'h41, 32'h9);
      wr(14'h41, 32'h7);
      ck_reg("p_load", 14'h42, 32'd4);
      chk("tcfg_keeps_ti", timer_int, 64'd1);
      wr(14'h44, 32'h1);
      ck_reg("p_3", 14'h42, 32'd3);
      chk("p_clr", timer_int, 64'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         ck_reg("p_tval", 14'h42, pv[i]);
         chk("p_ti", timer_int, 64'(pt[i]));
      end
      wr(14'h44, 32'h0);
      ck_reg("clr0_tval", 14'h42, 32'd3);
      chk("clr0_ti", timer_int, 64'd1);
      wr(14'h44, 32'h1);
      ck_reg("clr1_tval", 14'h42, 32'd2);
      chk("clr1_ti", timer_int, 64'd0);
      @(negedge clk);
      ck_reg("pre_exp", 14'h42, 32'd1);
      wr(14'h44, 32'h1);
      ck_reg("race_tval", 14'h42, 32'd0);
      chk("race_set_wins", timer_int, 64'd1);
      @(negedge clk);
      ck_reg("reload", 14'h42, 32'd4);
      wr(14'h41, 32'h11);
      ck_reg("d_load", 14'h42, 32'd16);
      wr(14'h44, 32'h1);
      ck_reg("d_15", 14'h42, 32'd15);
      chk("d_ti", timer_int, 64'd0);
      repeat (10) @(negedge clk);
      ck_reg("d_5", 14'h42, 32'd5);
      wr(14'h41, 32'h10);
      ck_reg("dis_load", 14'h42, 32'd16);
      ck_reg("dis_tcfg", 14'h41, 32'h10);
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         ck_reg("dis_hold", 14'h42, 32'd16);
         chk("dis_ti", timer_int, 64'd0);
      end
      wr(14'h41, 32'h1);
      repeat (10) @(negedge clk);
      ck_reg("iv0_tval", 14'h42, 32'd0);
      chk("iv0_ti", timer_int, 64'd0);
      wr(14'h41, 32'h3);
      repeat (10) @(negedge clk);
      ck_reg("iv0p_tval", 14'h42, 32'd0);
      chk("iv0p_ti", timer_int, 64'd0);
      wr(14'h41, 32'h7);
      repeat (3) @(negedge clk);
      ck_reg("wx_pre", 14'h42, 32'd1);
      wr(14'h41, 32'h9);
      ck_reg("wx_tval", 14'h42, 32'd8);
      chk("wx_ti", timer_int, 64'd1);
      wr(14'h41, 32'h7);
      repeat (6) @(negedge clk);
      chk("cnt_model", stable_cnt, exp_cnt);
      ck_reg("ar_pre_tval", 14'h42, 32'd3);
      chk("ar_pre_ti", timer_int, 64'd1);
      resetn = 1'b0;
      ck_reg("ar_tval", 14'h42, 32'd0);
      ck_reg("ar_tcfg", 14'h41, 32'd0);
      ck_reg("ar_tid", 14'h40, 32'd0);
      chk("ar_ti", timer_int, 64'd0);
      chk("ar_cnt", stable_cnt, 64'd0);
      @(negedge clk);
      resetn = 1'b1;
      repeat (5) @(negedge clk);
      ck_reg("post_tval", 14'h42, 32'd0);
      chk("post_ti", timer_int, 64'd0);
      chk("post_cnt", stable_cnt, 64'd5);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
